// File: rtl/fp8_pkg.sv
// Shared FP8 (E4M3) / BF16 field definitions and constants, used by both the
// unpacker here and the BF16->FP8 quantizer.
package fp8_pkg;

    localparam int unsigned FP8_EXP_W          = 4;
    localparam int unsigned FP8_MAN_W          = 3;
    localparam int unsigned FP8_BIAS           = 7;
    localparam int unsigned BF16_BIAS          = 127;
    localparam logic [7:0]  FP8_BF16_EXP_DELTA = 8'(BF16_BIAS - FP8_BIAS);
    localparam logic [6:0]  BF16_QNAN_PAYLOAD  = 7'h40;

    typedef struct packed {
        logic                 s;
        logic [FP8_EXP_W-1:0] e;
        logic [FP8_MAN_W-1:0] m;
    } fp8_t;

    typedef struct packed {
        logic       s;
        logic [7:0] e;
        logic [6:0] m;
    } bf16_t;

endpackage

// File: rtl/fp8_to_bf16_lane.sv
// Combinational decode of one E4M3 byte to BF16 with a NaN flag.
// FP8_SUBNORM_EN: normalize subnormals exactly; otherwise flush them to signed zero.
module fp8_to_bf16_lane
    import fp8_pkg::*;
(
    input  logic [7:0]  fp8,
    output logic [15:0] bf16,
    output logic        is_nan
);

    fp8_t  f;
    bf16_t r;

    assign f = fp8_t'(fp8);

    always_comb begin
        r      = '{s: f.s, e: 8'h00, m: 7'h00};
        is_nan = 1'b0;
        if (f.e == 4'hF && f.m == 3'h7) begin
            // E4M3 has no infinities; only the all-ones pattern is NaN
            r.e    = 8'hFF;
            r.m    = BF16_QNAN_PAYLOAD;
            is_nan = 1'b1;
        end else if (f.e != 4'h0) begin
            r.e = {4'h0, f.e} + FP8_BF16_EXP_DELTA;
            r.m = {f.m, 4'h0};
        end else if (f.m != 3'h0) begin
`ifdef FP8_SUBNORM_EN
            // value = 0.m * 2^-6; shift the leading one into the hidden bit
            if (f.m[2]) begin
                r.e = 8'd120;
                r.m = {f.m[1:0], 5'h00};
            end else if (f.m[1]) begin
                r.e = 8'd119;
                r.m = {f.m[0], 6'h00};
            end else begin
                r.e = 8'd118;
                r.m = 7'h00;
            end
`else
            r.e = 8'h00;
            r.m = 7'h00;
`endif
        end
        bf16 = r;
    end

endmodule

// File: rtl/fp8_to_bf16_unpacker.sv
// Streaming unpacker: one LANES-wide FP8 word in, one BF16 per cycle out, lane 0 first.
// Subnormal handling follows FP8_SUBNORM_EN in fp8_to_bf16_lane.
module fp8_to_bf16_unpacker
    import fp8_pkg::*;
#(
    parameter int unsigned LANES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [8*LANES-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [15:0]        out_bf16,
    output logic               out_last,
    output logic               nan_seen,
    input  logic               nan_clr
);

    localparam int unsigned LANE_W = $clog2(LANES);

    logic [8*LANES-1:0] hold;
    logic               full;
    logic [LANE_W-1:0]  lane;

    logic [7:0] cur_byte;
    logic       cur_nan;
    logic       accept;
    logic       emit;

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // A producer holds valid/data until it transfers; ready may depend on
    // the other side's ready (in_ready follows out_ready on the last lane).
    assign out_valid = full;
    assign out_last  = full && (lane == LANE_W'(LANES - 1));
    assign in_ready  = !full || (out_ready && out_last);
    assign accept    = in_valid && in_ready;
    assign emit      = out_valid && out_ready;

    assign cur_byte = hold[{lane, 3'b000} +: 8];

    fp8_to_bf16_lane u_lane (
        .fp8    (cur_byte),
        .bf16   (out_bf16),
        .is_nan (cur_nan)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold <= '0;
            full <= 1'b0;
            lane <= '0;
        end else if (accept) begin
            // also covers last-lane consume + new word in the same cycle
            hold <= in_data;
            full <= 1'b1;
            lane <= '0;
        end else if (emit) begin
            if (out_last) begin
                full <= 1'b0;
                lane <= '0;
            end else begin
                lane <= lane + LANE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nan_seen <= 1'b0;
        end else if (nan_clr) begin
            nan_seen <= 1'b0;
        end else if (emit && cur_nan) begin
            nan_seen <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fp8_to_bf16_unpacker.sv
// Directed bench for fp8_to_bf16_unpacker; expected BF16 values are hand-computed
// constants (subnormal expectations depend on FP8_SUBNORM_EN).
module tb_fp8_to_bf16_unpacker;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_bf16;
    logic        out_last;
    logic        nan_seen;
    logic        nan_clr;

    int checks;
    int failures;
    logic [15:0] exp_q[$];

    fp8_to_bf16_unpacker #(.LANES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bf16  (out_bf16),
        .out_last  (out_last),
        .nan_seen  (nan_seen),
        .nan_clr   (nan_clr)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // driver: offer a word at this negedge; it transfers on the next posedge
    task automatic drive_word(input logic [31:0] data);
        in_valid = 1'b1;
        in_data  = data;
    endtask

    // scoreboard: at a negedge, compare the current lane against the queue head
    task automatic expect_lane(input string tag, input logic exp_last, input logic exp_in_ready);
        logic [15:0] exp_v;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s scoreboard empty observed=%h", tag, out_bf16);
        end else begin
            exp_v = exp_q.pop_front();
            check1({tag, "_valid"}, out_valid, 1'b1);
            check16({tag, "_bf16"}, out_bf16, exp_v);
            check1({tag, "_last"}, out_last, exp_last);
            check1({tag, "_in_ready"}, in_ready, exp_in_ready);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        out_ready = 1'b0;
        nan_clr   = 1'b0;

        // reset state
        #2 rst_n = 1'b0;
        #1;
        check1("rst_out_valid", out_valid, 1'b0);
        check1("rst_in_ready", in_ready, 1'b1);
        check16("rst_out_bf16", out_bf16, 16'h0000);
        check1("rst_out_last", out_last, 1'b0);
        check1("rst_nan_seen", nan_seen, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // basic word: 1.0, -2.0, -0.0, NaN
        @(negedge clk);
        out_ready = 1'b1;
        drive_word(32'h7F80C038);
        exp_q.push_back(16'h3F80);
        exp_q.push_back(16'hC000);
        exp_q.push_back(16'h8000);
        exp_q.push_back(16'h7FC0);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            expect_lane($sformatf("basic_l%0d", i), i == 3, i == 3);
            @(negedge clk);
        end
        check1("basic_idle_valid", out_valid, 1'b0);
        check1("basic_nan_seen", nan_seen, 1'b1);

        // two words back-to-back, no bubble
        drive_word(32'hFE7E0104);
`ifdef FP8_SUBNORM_EN
        exp_q.push_back(16'h3C00);
        exp_q.push_back(16'h3B00);
`else
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0000);
`endif
        exp_q.push_back(16'h43E0);
        exp_q.push_back(16'hC3E0);
        exp_q.push_back(16'hBFF0);
        exp_q.push_back(16'hC000);
        exp_q.push_back(16'h4000);
        exp_q.push_back(16'h3F80);
        @(negedge clk);
        in_data = 32'h3840C0BF;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) in_valid = 1'b0;
            expect_lane($sformatf("b2b_%0d", i), (i % 4) == 3, (i % 4) == 3);
            @(negedge clk);
        end
        check1("b2b_idle_valid", out_valid, 1'b0);

        // backpressure on lane 1, then nan_clr racing the NaN emit
        drive_word(32'h7F80C038);
        exp_q.push_back(16'h3F80);
        exp_q.push_back(16'hC000);
        exp_q.push_back(16'h8000);
        exp_q.push_back(16'h7FC0);
        @(negedge clk);
        in_valid = 1'b0;
        expect_lane("bp_l0", 1'b0, 1'b0);
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check16($sformatf("bp_hold_bf16_%0d", i), out_bf16, 16'hC000);
            check1($sformatf("bp_hold_in_ready_%0d", i), in_ready, 1'b0);
            check1($sformatf("bp_hold_valid_%0d", i), out_valid, 1'b1);
            check1($sformatf("bp_hold_last_%0d", i), out_last, 1'b0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        expect_lane("bp_l1", 1'b0, 1'b0);
        @(negedge clk);
        expect_lane("bp_l2", 1'b0, 1'b0);
        @(negedge clk);
        check1("clr_pre_nan_seen", nan_seen, 1'b1);
        expect_lane("bp_l3", 1'b1, 1'b1);
        nan_clr = 1'b1;
        @(negedge clk);
        nan_clr = 1'b0;
        check1("clr_priority_nan_seen", nan_seen, 1'b0);
        @(negedge clk);
        check1("clr_stays_nan_seen", nan_seen, 1'b0);

        // asynchronous reset in the middle of a word
        drive_word(32'h7F80C038);
        exp_q.push_back(16'h3F80);
        exp_q.push_back(16'hC000);
        @(negedge clk);
        in_valid = 1'b0;
        expect_lane("mid_l0", 1'b0, 1'b0);
        @(negedge clk);
        expect_lane("mid_l1", 1'b0, 1'b0);
        @(negedge clk);
        check16("mid_l2_bf16", out_bf16, 16'h8000);
        rst_n = 1'b0;
        #1;
        check1("mid_rst_valid", out_valid, 1'b0);
        check16("mid_rst_bf16", out_bf16, 16'h0000);
        check1("mid_rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check1("post_rst_in_ready", in_ready, 1'b1);
        check1("post_rst_valid", out_valid, 1'b0);
        @(negedge clk);
        check1("post_rst_idle_valid", out_valid, 1'b0);
        drive_word(32'h3840C0BF);
        exp_q.push_back(16'hBFF0);
        exp_q.push_back(16'hC000);
        @(negedge clk);
        in_valid = 1'b0;
        expect_lane("post_l0", 1'b0, 1'b0);
        @(negedge clk);
        expect_lane("post_l1", 1'b0, 1'b0);
        @(negedge clk);
        check16("post_l2_bf16", out_bf16, 16'h4000);

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
